// File: rtl/half_duplex_pin_ctrl.sv
// Half-duplex single-pin serial controller: shifts a byte out LSB first or samples one in,
// with a released-pad turnaround between directions.
module half_duplex_pin_ctrl #(
  parameter int unsigned BITLEN = 4,
  parameter int unsigned TURN   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       rx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       pad_o,
  output logic       pad_t,
  input  logic       pad_i
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BITLEN - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN - 1);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(BITLEN / 2);
  localparam logic [BIT_W-1:0] BIT_MAX   = BIT_W'(7);

  typedef enum logic [2:0] {
    IDLE,
    TX_BIT,
    TX_TURN,
    RX_TURN,
    RX_BIT
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BYTE_W-1:0]   tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0]   rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_ready_q, tx_ready_d;
  logic                busy_q, busy_d;
  logic                pad_o_q, pad_o_d;
  logic                pad_t_q, pad_t_d;
  logic                sync1_q, sync2_q;

  // Next-state, counter and datapath logic; outputs follow the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q + CNT_W'(1);
    bit_d      = bit_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (tx_valid && tx_ready_q) begin
          state_d    = TX_BIT;
          tx_shift_d = tx_data;
        end else if (rx_req && !tx_valid) begin
          state_d = RX_TURN;
        end
      end
      TX_BIT: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_MAX) begin
            state_d = TX_TURN;
          end else begin
            bit_d      = bit_q + BIT_W'(1);
            tx_shift_d = tx_shift_q >> 1;
          end
        end
      end
      TX_TURN: begin
        if (cyc_q == TURN_LAST) state_d = IDLE;
      end
      RX_TURN: begin
        if (cyc_q == TURN_LAST) state_d = RX_BIT;
      end
      RX_BIT: begin
        if (cyc_q == SAMPLE_AT) rx_shift_d[bit_q] = sync2_q;
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_MAX) begin
            state_d    = IDLE;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_d;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Both counters restart on every state entry.
    if (state_d != state_q) begin
      cyc_d = '0;
      bit_d = '0;
    end

    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    pad_t_d    = (state_d != TX_BIT);
    pad_o_d    = (state_d == TX_BIT) ? tx_shift_d[0] : 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      pad_o_q    <= 1'b1;
      pad_t_q    <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      pad_o_q    <= pad_o_d;
      pad_t_q    <= pad_t_d;
      sync1_q    <= pad_i;
      sync2_q    <= sync1_q;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign pad_o    = pad_o_q;
  assign pad_t    = pad_t_q;

endmodule

// File: tb/tb_half_duplex_pin_ctrl.sv
// Directed bench for half_duplex_pin_ctrl: instance a (BITLEN=4, TURN=2) and
// instance b (BITLEN=2, TURN=1) on a shared clock and reset.
module tb_half_duplex_pin_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  logic [7:0] a_tx_data, b_tx_data;
  logic       a_tx_valid, b_tx_valid;
  logic       a_tx_ready, b_tx_ready;
  logic       a_rx_req, b_rx_req;
  logic [7:0] a_rx_data, b_rx_data;
  logic       a_rx_valid, b_rx_valid;
  logic       a_busy, b_busy;
  logic       a_pad_o, b_pad_o;
  logic       a_pad_t, b_pad_t;
  logic       a_pad_i, b_pad_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  half_duplex_pin_ctrl #(.BITLEN(4), .TURN(2)) u_a (
    .clk(clk), .reset_n(reset_n),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_req(a_rx_req), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .busy(a_busy), .pad_o(a_pad_o), .pad_t(a_pad_t), .pad_i(a_pad_i)
  );

  half_duplex_pin_ctrl #(.BITLEN(2), .TURN(1)) u_b (
    .clk(clk), .reset_n(reset_n),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_req(b_rx_req), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .busy(b_busy), .pad_o(b_pad_o), .pad_t(b_pad_t), .pad_i(b_pad_i)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receive one byte; strict mode drives the true bit only in the cycle that should be sampled.
  task automatic run_rx(input bit sel_b, input logic [7:0] byte_v, input int bl, input int tn,
                        input bit strict, input string tag);
    int vcount = 0;
    int vcycle = -1;
    int t_rel;
    int k;
    logic [7:0] got = 8'h00;
    logic pt_low = 1'b0;
    logic pbit;
    logic rv, pt;
    for (int t = 0; t < 60; t++) begin
      t_rel = t - (tn - 1);
      pbit  = 1'b1;
      if (t_rel >= 0 && t_rel < 8 * bl) begin
        k    = t_rel / bl;
        pbit = byte_v[k];
        if (strict && (t_rel % bl) != bl / 2) pbit = ~byte_v[k];
      end
      if (sel_b) begin
        b_pad_i  = pbit;
        b_rx_req = (t == 0);
      end else begin
        a_pad_i  = pbit;
        a_rx_req = (t == 0);
      end
      tick();
      rv = sel_b ? b_rx_valid : a_rx_valid;
      pt = sel_b ? b_pad_t : a_pad_t;
      if (rv) begin
        vcount++;
        vcycle = t + 1;
        got    = sel_b ? b_rx_data : a_rx_data;
      end
      if (!pt) pt_low = 1'b1;
    end
    a_pad_i = 1'b1;
    b_pad_i = 1'b1;
    check({tag, "_valid_count"}, 32'(vcount), 32'd1);
    check({tag, "_valid_cycle"}, 32'(vcycle), 32'(tn + 8 * bl + 1));
    check({tag, "_data"}, 32'(got), 32'(byte_v));
    check({tag, "_data_hold"}, 32'(sel_b ? b_rx_data : a_rx_data), 32'(byte_v));
    check({tag, "_pad_t_low"}, 32'(pt_low), 32'd0);
    check({tag, "_busy_end"}, 32'(sel_b ? b_busy : a_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] txb;
    logic seen;
    int rise, fall, ones1, zeros2;
    logic prev_t;

    reset_n    = 1'b0;
    a_tx_data  = 8'h00; a_tx_valid = 1'b0; a_rx_req = 1'b0; a_pad_i = 1'b1;
    b_tx_data  = 8'h00; b_tx_valid = 1'b0; b_rx_req = 1'b0; b_pad_i = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_pad_t", 32'(a_pad_t), 32'd1);
    check("rst_pad_o", 32'(a_pad_o), 32'd1);
    check("rst_tx_ready", 32'(a_tx_ready), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_rx_valid", 32'(a_rx_valid), 32'd0);
    check("rst_rx_data", 32'(a_rx_data), 32'd0);
    reset_n = 1'b1;
    check("rel_tx_ready_before", 32'(a_tx_ready), 32'd0);
    tick();
    check("rel_tx_ready_after", 32'(a_tx_ready), 32'd1);

    // Transmit A5
    txb = 8'hA5;
    a_tx_data = txb; a_tx_valid = 1'b1;
    tick();
    a_tx_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("txA5_pad_t", 32'(a_pad_t), 32'd0);
      check("txA5_pad_o", 32'(a_pad_o), 32'(txb[i / 4]));
      if (i == 0) begin
        check("txA5_tx_ready", 32'(a_tx_ready), 32'd0);
        check("txA5_busy", 32'(a_busy), 32'd1);
      end
      tick();
    end
    for (int j = 0; j < 2; j++) begin
      check("txA5_turn_pad_t", 32'(a_pad_t), 32'd1);
      check("txA5_turn_pad_o", 32'(a_pad_o), 32'd1);
      check("txA5_turn_tx_ready", 32'(a_tx_ready), 32'd0);
      tick();
    end
    check("txA5_idle_tx_ready", 32'(a_tx_ready), 32'd1);
    check("txA5_idle_busy", 32'(a_busy), 32'd0);

    // Receive 3C, full-width windows
    run_rx(1'b0, 8'h3C, 4, 2, 1'b0, "rx3C");

    // Simultaneous tx_valid/rx_req, then rx_req during TX_BIT
    a_tx_data = 8'h5A; a_tx_valid = 1'b1; a_rx_req = 1'b1;
    tick();
    a_tx_valid = 1'b0; a_rx_req = 1'b0;
    check("coll_pad_t", 32'(a_pad_t), 32'd0);
    check("coll_pad_o", 32'(a_pad_o), 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      a_rx_req = (n == 5);
      tick();
      if (a_rx_valid) seen = 1'b1;
    end
    a_rx_req = 1'b0;
    check("coll_no_rx_valid", 32'(seen), 32'd0);
    check("coll_busy_end", 32'(a_busy), 32'd0);

    // Reset during bit 3 of a transmit
    a_tx_data = 8'h00; a_tx_valid = 1'b1;
    tick();
    a_tx_valid = 1'b0;
    for (int n = 0; n < 13; n++) tick();
    check("mid_pad_t_before", 32'(a_pad_t), 32'd0);
    check("mid_pad_o_before", 32'(a_pad_o), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_pad_t_async", 32'(a_pad_t), 32'd1);
    check("mid_pad_o_async", 32'(a_pad_o), 32'd1);
    check("mid_busy_async", 32'(a_busy), 32'd0);
    check("mid_rx_data_clr", 32'(a_rx_data), 32'd0);
    tick(); tick();
    check("mid_tx_ready_rst", 32'(a_tx_ready), 32'd0);
    check("mid_rx_valid_rst", 32'(a_rx_valid), 32'd0);
    reset_n = 1'b1;
    check("mid_tx_ready_rel", 32'(a_tx_ready), 32'd0);
    tick();
    check("mid_tx_ready_after", 32'(a_tx_ready), 32'd1);
    check("mid_pad_t_after", 32'(a_pad_t), 32'd1);

    // Back-to-back FF then 00 with tx_valid held
    a_tx_data = 8'hFF; a_tx_valid = 1'b1;
    tick();
    a_tx_data = 8'h00;
    rise = -1; fall = -1; ones1 = 0; zeros2 = 0;
    prev_t = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (n < 32 && a_pad_o) ones1++;
      if (!prev_t && a_pad_t && rise < 0) rise = n;
      if (prev_t && !a_pad_t && rise >= 0 && fall < 0) begin
        fall = n;
        a_tx_valid = 1'b0;
      end
      if (fall >= 0 && n < fall + 32 && !a_pad_t && !a_pad_o) zeros2++;
      prev_t = a_pad_t;
      tick();
    end
    a_tx_valid = 1'b0;
    check("b2b_rise", 32'(rise), 32'd32);
    check("b2b_gap", 32'(fall - rise), 32'd3);
    check("b2b_ff_bits", 32'(ones1), 32'd32);
    check("b2b_00_bits", 32'(zeros2), 32'd32);
    check("b2b_busy_end", 32'(a_busy), 32'd0);

    // Minimum timing: BITLEN=2, TURN=1, sampled only at in-window index 1
    run_rx(1'b1, 8'h81, 2, 1, 1'b1, "rx81");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/half_duplex_pin_ctrl.md
HALF_DUPLEX_PIN_CTRL -- requirements
Module: half_duplex_pin_ctrl

Interface
REQ-001 Parameter BITLEN, default 4: clock cycles per serial bit; legal range 2..255, even values only.
REQ-002 Parameter TURN, default 2: bus-turnaround cycles with the pad released; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  8  byte to transmit, LSB first.
REQ-006 tx_valid  input  1  transmit request; qualifies tx_data.
REQ-007 tx_ready  output  1  block can accept a transmit byte this cycle.
REQ-008 rx_req  input  1  single-cycle request to receive one byte.
REQ-009 rx_data  output  8  last received byte; stable until next rx_valid.
REQ-010 rx_valid  output  1  one-cycle pulse: rx_data is new.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 pad_o  output  1  data toward the tri-state pad buffer I input.
REQ-013 pad_t  output  1  pad buffer enable toward its T input; 1 = released (high-Z), 0 = driven.
REQ-014 pad_i  input  1  pad buffer O input; asynchronous to clk.

Function
REQ-015 The block SHALL pass pad_i through a 2-flop synchronizer; the sampled value is sync_i.
REQ-016 The FSM SHALL have states IDLE, TX_BIT, TX_TURN, RX_TURN, RX_BIT.
REQ-017 In IDLE the block SHALL drive tx_ready=1, busy=0, pad_t=1 and pad_o=1.
REQ-018 A transmit is accepted on the rising edge where tx_valid=1 and tx_ready=1; tx_data is captured into a shift register and the FSM enters TX_BIT.
REQ-019 When tx_valid=1 and rx_req=1 in the same IDLE cycle, the block SHALL accept the transmit and ignore rx_req.
REQ-020 The block SHALL ignore rx_req while not in IDLE.
REQ-021 In TX_BIT the block SHALL drive pad_t=0 and pad_o=shift[0]; each bit is held exactly BITLEN cycles, bits 0..7 in order.
REQ-022 pad_t SHALL fall in the first cycle after acceptance and stay low for exactly 8*BITLEN cycles.
REQ-023 After bit 7 the FSM SHALL enter TX_TURN with pad_t=1 and pad_o=1 for exactly TURN cycles, then return to IDLE.
REQ-024 pad_t and pad_o SHALL be registered outputs, glitch-free, and never change in the same cycle as a direction change except as required by REQ-021 and REQ-023.
REQ-025 On rx_req=1 in IDLE with tx_valid=0, the FSM SHALL enter RX_TURN and keep pad_t=1 for TURN cycles, then enter RX_BIT.
REQ-026 In RX_BIT, pad_t SHALL remain 1; for bit window k (0..7, BITLEN cycles each), sync_i SHALL be sampled once at in-window cycle index BITLEN/2 (0-based) into bit k of the receive shift register.
REQ-027 In the cycle after window 7 ends, the block SHALL load rx_data, pulse rx_valid for exactly one cycle, and return to IDLE.
REQ-028 The bit-cycle counter SHALL be 8 bits wide and the bit counter 3 bits wide; both SHALL clear on every state entry.
REQ-029 tx_ready SHALL be 0 in every state except IDLE; a back-to-back transmit is therefore separated by at least TURN+1 released cycles.

Reset
REQ-030 While reset_n=0, outputs SHALL be forced asynchronously to: pad_t=1, pad_o=1, tx_ready=0, busy=0, rx_valid=0 and rx_data=8'h00.
REQ-031 While reset_n=0, the FSM SHALL be held in IDLE, counters and shift registers SHALL be cleared, and the synchronizer flops SHALL be set to 1.
REQ-032 tx_ready SHALL rise in the first clock cycle after reset_n is released.
REQ-033 Asserting reset mid-transfer SHALL release the pad immediately (pad_t=1) without a turnaround and SHALL NOT pulse rx_valid.

Verification
REQ-034 Transmit with BITLEN=4 and TURN=2, tx_data=8'hA5 -> pad_t low for 32 cycles; pad_o sequence 1,0,1,0,0,1,0,1 at 4 cycles per bit; then 2 cycles with pad_t=1; then tx_ready=1.
REQ-035 Receive with pad_i driven with 8'h3C (LSB first, 4 cycles per bit, aligned to RX_BIT entry plus 2-cycle synchronizer lag) -> rx_valid pulse of 1 cycle with rx_data=8'h3C; pad_t=1 throughout.
REQ-036 tx_valid=1 and rx_req=1 in the same IDLE cycle -> transmit occurs and no rx_valid follows; rx_req pulsed during TX_BIT -> ignored.
REQ-037 reset_n driven low at bit 3 of a transmit -> pad_t=1 and pad_o=1 in the same cycle, tx_ready=0 during reset, tx_ready=1 one cycle after release.
REQ-038 Back-to-back transmit of 8'hFF then 8'h00 with tx_valid held high -> second byte accepted exactly TURN+1 cycles after pad_t rises; pad_t never low during TX_TURN.
REQ-039 Boundary check with BITLEN=2 and TURN=1, receive of 8'h81 -> correct data, with samples taken at in-window index 1.
